// File: rtl/dma_word_counter.sv
// Up/down address/word counter for one DMA channel: initial register, cascade carry,
// wrap/stop/reload terminal-count modes. Optional tc_pulse output under `DMA_TC_PULSE_EN.
module dma_word_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             load,
  input  logic             reinit,
  input  logic             enable,
  input  logic             cin,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] init_out,
  output logic             carry_out,
  output logic             done,
`ifdef DMA_TC_PULSE_EN
  output logic             tc_pulse,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_RELOAD = 2'b10;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;

  logic             boundary;
  logic             step;
  logic [WIDTH-1:0] count_next;

  // Boundary follows the current direction, so a flip of up moves the terminal value.
  assign boundary   = up ? (count_q == {WIDTH{1'b1}}) : (count_q == '0);
  assign step       = enable & cin & (state_q == ST_RUN);
  assign count_next = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

  // Carry ignores the FSM state so a cascaded stage behaves like the original 4-bit part.
  assign carry_out  = enable & cin & boundary;

  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips an assignment infers a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    init_d  = init_q;
    done_d  = done_q;
    tc_d    = 1'b0;

    if (load) begin
      count_d = data_in;
      init_d  = data_in;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (reinit) begin
      count_d = init_q;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (step) begin
      if (boundary) begin
        done_d = 1'b1;
        tc_d   = 1'b1;
        unique case (mode)
          MODE_WRAP:   count_d = count_next;
          MODE_RELOAD: count_d = init_q;
          default:     state_d = ST_HALT;
        endcase
      end else begin
        count_d = count_next;
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  // NOTE: the initial-value register is an ordinary flop, not a memory, so it is
  // cleared by reset together with the count.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
      count_q <= RESET_VAL;
      init_q  <= RESET_VAL;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      init_q  <= init_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
    end
  end

  assign count_out = count_q;
  assign init_out  = init_q;
  assign done      = done_q;
  assign busy      = busy_q;

`ifdef DMA_TC_PULSE_EN
  assign tc_pulse = tc_q;
`else
  logic unused_tc;
  assign unused_tc = tc_q;
`endif

endmodule

// File: tb/tb_dma_word_counter.sv
// Scoreboard bench for dma_word_counter: stimulus pushes model predictions, a monitor
// pops and compares; also covers async reset and a two-stage 4-bit cascade.
module tb_dma_word_counter;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         load = 1'b0, reinit = 1'b0, enable = 1'b0, cin = 1'b1, up = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] count_out, init_out;
  logic         carry_out, done, busy;
`ifdef DMA_TC_PULSE_EN
  logic         tc_pulse;
`endif

  always #5 clk = ~clk;

  dma_word_counter #(.WIDTH(W)) dut (
    .clk(clk), .res_n(res_n), .load(load), .reinit(reinit), .enable(enable),
    .cin(cin), .up(up), .mode(mode), .data_in(data_in),
    .count_out(count_out), .init_out(init_out), .carry_out(carry_out),
    .done(done),
`ifdef DMA_TC_PULSE_EN
    .tc_pulse(tc_pulse),
`endif
    .busy(busy)
  );

  // Two-stage 4-bit cascade
  logic       c_load = 1'b0, c_en = 1'b0;
  logic [3:0] lo_cnt, hi_cnt, lo_init, hi_init;
  logic       lo_carry, hi_carry, lo_done, hi_done, lo_busy, hi_busy;
`ifdef DMA_TC_PULSE_EN
  logic       lo_tc, hi_tc;
`endif

  dma_word_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .res_n(res_n), .load(c_load), .reinit(1'b0), .enable(c_en),
    .cin(1'b1), .up(1'b1), .mode(2'b00), .data_in(4'hF),
    .count_out(lo_cnt), .init_out(lo_init), .carry_out(lo_carry), .done(lo_done),
`ifdef DMA_TC_PULSE_EN
    .tc_pulse(lo_tc),
`endif
    .busy(lo_busy)
  );

  dma_word_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .res_n(res_n), .load(c_load), .reinit(1'b0), .enable(c_en),
    .cin(lo_carry), .up(1'b1), .mode(2'b00), .data_in(4'h0),
    .count_out(hi_cnt), .init_out(hi_init), .carry_out(hi_carry), .done(hi_done),
`ifdef DMA_TC_PULSE_EN
    .tc_pulse(hi_tc),
`endif
    .busy(hi_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         carry;
    logic [W-1:0] count;
    logic [W-1:0] init;
    logic         done;
    logic         busy;
    logic         tc;
  } exp_t;

  exp_t sb[$];
  int   n_pushed = 0;
  int   n_popped = 0;
  bit   mon_busy = 1'b0;

  // Reference model: plain integer count, "loaded" and "halted" flags.
  int m_count = 0, m_init = 0;
  bit m_done = 0, m_loaded = 0, m_halted = 0, m_tc = 0;

  task automatic model_reset();
    m_count = 0; m_init = 0; m_done = 0; m_loaded = 0; m_halted = 0; m_tc = 0;
  endtask

  task automatic issue(input bit ld, input bit ri, input bit en, input bit ci,
                       input bit u, input bit [1:0] md, input bit [W-1:0] d);
    exp_t e;
    int   nxt;
    @(negedge clk);
    #1;
    load = ld; reinit = ri; enable = en; cin = ci; up = u; mode = md; data_in = d;
    e.carry = en & ci & (u ? (m_count == MAXV) : (m_count == 0));
    m_tc = 0;
    if (ld) begin
      m_count = int'(d); m_init = int'(d); m_done = 0; m_loaded = 1; m_halted = 0;
    end else if (ri) begin
      m_count = m_init; m_done = 0; m_loaded = 1; m_halted = 0;
    end else if (en && ci && m_loaded && !m_halted) begin
      nxt = u ? m_count + 1 : m_count - 1;
      if (nxt < 0 || nxt > MAXV) begin
        m_done = 1;
        m_tc   = 1;
        if (md == 2'b00)      m_count = (nxt + MAXV + 1) % (MAXV + 1);
        else if (md == 2'b10) m_count = m_init;
        else                  m_halted = 1;
      end else begin
        m_count = nxt;
      end
    end
    e.count = W'(m_count);
    e.init  = W'(m_init);
    e.done  = m_done;
    e.busy  = m_loaded && !m_halted;
    e.tc    = m_tc;
    sb.push_back(e);
    n_pushed++;
  endtask

  // Monitor: carry_out is checked before the edge, registers after it.
  initial begin
    exp_t e;
    forever begin
      wait (n_pushed != n_popped);
      #2;
      e = sb.pop_front();
      n_popped++;
      mon_busy = 1'b1;
      check("carry_out", 32'(carry_out), 32'(e.carry));
      @(negedge clk);
      check("count_out", 32'(count_out), 32'(e.count));
      check("init_out",  32'(init_out),  32'(e.init));
      check("done",      32'(done),      32'(e.done));
      check("busy",      32'(busy),      32'(e.busy));
`ifdef DMA_TC_PULSE_EN
      check("tc_pulse",  32'(tc_pulse),  32'(e.tc));
`endif
      mon_busy = 1'b0;
    end
  end

  // Let the last issued edge happen, idle the inputs, then wait for the monitor.
  task automatic drain();
    int k = 0;
    @(posedge clk);
    #1;
    load = 1'b0; reinit = 1'b0; enable = 1'b0;
    while (!(n_pushed == n_popped && !mon_busy) && k < 50) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (k >= 50) begin
      total++; bad++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", n_pushed - n_popped);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [W-1:0] d;
    bit         u = 1'b1;
    int         r;

    // Reset state, no clock edge seen yet
    #2;
    check("rst_count", 32'(count_out), 0);
    check("rst_init",  32'(init_out),  0);
    check("rst_done",  32'(done),      0);
    check("rst_busy",  32'(busy),      0);
    @(negedge clk);
    res_n = 1'b1;
    model_reset();

    // IDLE ignores enable; carry still reflects the boundary
    repeat (2) issue(0, 0, 1, 1, 1, 2'b00, 8'h00);
    issue(0, 0, 1, 1, 0, 2'b00, 8'h00);

    // Up, wrap
    issue(1, 0, 1, 1, 1, 2'b00, 8'hFE);
    repeat (4) issue(0, 0, 1, 1, 1, 2'b00, 8'h00);

    // Down, stop, then reinit
    issue(1, 0, 1, 1, 0, 2'b01, 8'h02);
    repeat (5) issue(0, 0, 1, 1, 0, 2'b01, 8'h00);
    issue(0, 1, 0, 1, 0, 2'b01, 8'h00);
    repeat (2) issue(0, 0, 1, 1, 0, 2'b01, 8'h00);

    // Reload
    issue(1, 0, 1, 1, 1, 2'b10, 8'hFD);
    repeat (8) issue(0, 0, 1, 1, 1, 2'b10, 8'h00);

    // Mode 11 acts as stop
    issue(1, 0, 1, 1, 1, 2'b11, 8'hFF);
    repeat (2) issue(0, 0, 1, 1, 1, 2'b11, 8'h00);

    // Priority load > reinit > step, then cin gating
    issue(1, 1, 1, 1, 1, 2'b00, 8'h55);
    repeat (2) issue(0, 0, 1, 0, 1, 2'b00, 8'h00);
    issue(0, 0, 1, 1, 1, 2'b00, 8'h00);

    // Randomized traffic biased towards the boundaries
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 4));
      if (r == 0)      d = 8'h00;
      else if (r == 1) d = 8'h01;
      else if (r == 2) d = 8'hFE;
      else if (r == 3) d = 8'hFF;
      else             d = W'($urandom);
      if ($urandom_range(0, 31) == 0) u = ~u;
      issue($urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
            u, 2'($urandom), d);
    end
    drain();

    // Asynchronous reset mid-count, between clock edges
    issue(1, 0, 1, 1, 1, 2'b00, 8'h40);
    repeat (2) issue(0, 0, 1, 1, 1, 2'b00, 8'h00);
    drain();
    enable = 1'b1;
    @(posedge clk);
    #3;
    res_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count_out), 0);
    check("async_rst_init",  32'(init_out),  0);
    check("async_rst_done",  32'(done),      0);
    check("async_rst_busy",  32'(busy),      0);
    @(negedge clk);
    res_n = 1'b1;
    model_reset();
    repeat (3) issue(0, 0, 1, 1, 1, 2'b00, 8'h00);
    drain();

    // Cascade: low stage carry drives high stage cin
    @(negedge clk);
    c_load = 1'b1;
    c_en   = 1'b1;
    @(posedge clk);
    #1;
    c_load = 1'b0;
    check("casc_load",     32'({hi_cnt, lo_cnt}), 32'h0F);
    check("casc_lo_carry", 32'(lo_carry), 1);
    @(posedge clk);
    #1;
    check("casc_step1",    32'({hi_cnt, lo_cnt}), 32'h10);
    check("casc_lo_carry2", 32'(lo_carry), 0);
    @(posedge clk);
    #1;
    check("casc_step2",    32'({hi_cnt, lo_cnt}), 32'h11);
    c_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
